// File: rtl/neuron_pkg.sv
// Shared types, default widths and saturation bounds for the neuron accumulator.
// Bounds come back as 64-bit signed values, and callers truncate them to their own width.
package neuron_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_BIAS,
        ST_OUT
    } state_e;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_BIAS_W = 8;
    localparam int DEF_ACC_W  = 24;
    localparam int DEF_OUT_W  = 16;
    localparam int DEF_CNT_W  = 8;

    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational signed adder that clamps to the W-bit signed range.
// The sat output flags the cycles on which clamping took place.
module sat_add
    import neuron_pkg::*;
#(
    parameter int W = DEF_ACC_W
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic                sat
);

    localparam logic signed [63:0] MAX64 = sat_max(W);
    localparam logic signed [63:0] MIN64 = sat_min(W);
    localparam logic signed [W-1:0] MAXV = MAX64[W-1:0];
    localparam logic signed [W-1:0] MINV = MIN64[W-1:0];

    logic [W:0] s;

    always_comb begin
        s   = {a[W-1], a} + {b[W-1], b};
        sat = s[W] ^ s[W-1];
        sum = s[W-1:0];
        if (sat) begin
            sum = s[W] ? MINV : MAXV;
        end
    end

endmodule

// File: rtl/neuron_accum.sv
// Neuron evaluator: sums cfg_len signed terms plus a bias with saturation,
// then presents the clamped result through a valid/ready handshake.
module neuron_accum
    import neuron_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int BIAS_W = DEF_BIAS_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [CNT_W-1:0]         cfg_len,
    input  logic signed [BIAS_W-1:0] bias,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_sat,
    output logic                     busy
);

    localparam logic signed [63:0] OMAX64 = sat_max(OUT_W);
    localparam logic signed [63:0] OMIN64 = sat_min(OUT_W);
    localparam logic signed [ACC_W-1:0] OMAX = OMAX64[ACC_W-1:0];
    localparam logic signed [ACC_W-1:0] OMIN = OMIN64[ACC_W-1:0];

    state_e state, state_d;

    logic signed [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]         cnt;
    logic signed [BIAS_W-1:0] bias_q;
    logic                     sat_q;
    logic signed [OUT_W-1:0]  out_q;

    logic signed [ACC_W-1:0]  add_b;
    logic signed [ACC_W-1:0]  add_sum;
    logic                     add_sat;
    logic signed [ACC_W-1:0]  clamp;
    logic                     out_of;

    // One adder serves both the term path and the bias path.
    always_comb begin
        if (state == ST_BIAS) begin
            add_b = {{(ACC_W-BIAS_W){bias_q[BIAS_W-1]}}, bias_q};
        end else begin
            add_b = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
        end
    end

    sat_add #(
        .W(ACC_W)
    ) u_sat_add (
        .a  (acc),
        .b  (add_b),
        .sum(add_sum),
        .sat(add_sat)
    );

    always_comb begin
        clamp  = add_sum;
        out_of = 1'b0;
        if (add_sum > OMAX) begin
            clamp  = OMAX;
            out_of = 1'b1;
        end else if (add_sum < OMIN) begin
            clamp  = OMIN;
            out_of = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d = (cfg_len != '0) ? ST_ACCUM : ST_BIAS;
                end
            end
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && cnt == CNT_W'(1)) begin
                    state_d = ST_BIAS;
                end
            end
            ST_BIAS: begin
                state_d = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            cnt    <= '0;
            bias_q <= '0;
            sat_q  <= 1'b0;
            out_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        cnt    <= cfg_len;
                        bias_q <= bias;
                        sat_q  <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    if (in_valid) begin
                        acc   <= add_sum;
                        cnt   <= cnt - CNT_W'(1);
                        sat_q <= sat_q | add_sat;
                    end
                end
                ST_BIAS: begin
                    out_q <= clamp[OUT_W-1:0];
                    sat_q <= sat_q | add_sat | out_of;
                end
                default: begin
                end
            endcase
        end
    end

    assign out_data = out_q;
    assign out_sat  = sat_q;

endmodule

// File: tb/tb_neuron_accum.sv
// Self-checking bench for neuron_accum against an arithmetic reference model.
// Latency is counted from the cycle a beat (or start) is presented.
module tb_neuron_accum;

    localparam longint ACC_MAX = (64'sd1 <<< 23) - 1;
    localparam longint ACC_MIN = -(64'sd1 <<< 23);
    localparam longint OUT_MAX = 32767;
    localparam longint OUT_MIN = -32768;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [7:0]         cfg_len = '0;
    logic signed [7:0]  bias = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] in_data = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic signed [15:0] out_data;
    logic               out_sat;
    logic               busy;

    int compared = 0;
    int mismatched = 0;
    int terms[$];

    neuron_accum dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cfg_len  (cfg_len),
        .bias     (bias),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sat  (out_sat),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic void model(input int b, output longint res, output bit sat);
        longint a = 0;
        sat = 0;
        foreach (terms[i]) begin
            a += terms[i];
            if (a > ACC_MAX) begin a = ACC_MAX; sat = 1; end
            else if (a < ACC_MIN) begin a = ACC_MIN; sat = 1; end
        end
        a += b;
        if (a > ACC_MAX) begin a = ACC_MAX; sat = 1; end
        else if (a < ACC_MIN) begin a = ACC_MIN; sat = 1; end
        if (a > OUT_MAX) begin a = OUT_MAX; sat = 1; end
        else if (a < OUT_MIN) begin a = OUT_MIN; sat = 1; end
        res = a;
    endfunction

    // Runs one evaluation from IDLE; called at posedge+1.
    task automatic drive_eval(input int b, input int gap_pct, input int hold, input bit poke,
                              output logic signed [15:0] od, output logic os, output int lat,
                              output int rdy, output bit stable, output bit idle_after,
                              output bit to);
        int idx;
        int n;
        int guard;
        n = terms.size();
        rdy = 0; to = 0; stable = 1; idle_after = 0; od = '0; os = 0;
        cfg_len = 8'(n);
        bias = 8'(b);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        idx = 0;
        guard = 0;
        while (idx < n && !to) begin
            bit take;
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data = 16'(terms[idx]);
            if (poke) start = $urandom_range(1) == 1;
            if (in_ready) rdy++;
            take = in_valid && in_ready;
            @(posedge clk); #1;
            if (take) begin idx++; lat = 1; end
            guard++;
            if (guard > 5000) to = 1;
        end
        in_valid = 1'b0;
        start = 1'b0;
        guard = 0;
        while (!out_valid && !to) begin
            if (in_ready) rdy++;
            @(posedge clk); #1;
            lat++;
            guard++;
            if (guard > 100) to = 1;
        end
        od = out_data;
        os = out_sat;
        for (int h = 0; h < hold; h++) begin
            start = poke;
            out_ready = 1'b0;
            @(posedge clk); #1;
            if (out_data !== od || out_sat !== os || out_valid !== 1'b1) stable = 0;
        end
        start = poke;
        out_ready = 1'b1;
        @(posedge clk); #1;
        idle_after = (busy === 1'b0 && out_valid === 1'b0);
        out_ready = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        compared++;
        if ({out_valid, in_ready, busy, out_sat} !== 4'b0 || out_data !== 16'sd0) begin
            mismatched++;
            $display("FAIL reset: ov=%b ir=%b busy=%b sat=%b data=%0d want all 0",
                     out_valid, in_ready, busy, out_sat, out_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_basic();
        logic signed [15:0] od; logic os; int lat, rdy; bit st, idl, to;
        terms = '{100, 200, -50};
        drive_eval(-5, 0, 0, 0, od, os, lat, rdy, st, idl, to);
        compared++;
        if (to !== 1'b0 || od !== 16'sd245 || os !== 1'b0) begin
            mismatched++;
            $display("FAIL basic: to=%b data=%0d sat=%b want 245 sat 0", to, od, os);
        end
        compared++;
        if (lat !== 2) begin
            mismatched++;
            $display("FAIL basic_latency: got %0d want 2", lat);
        end
        compared++;
        if (idl !== 1'b1) begin
            mismatched++;
            $display("FAIL basic_idle: got %b want 1", idl);
        end
    endtask

    task automatic test_saturate();
        logic signed [15:0] od; logic os; int lat, rdy; bit st, idl, to;
        terms = '{32767, 32767};
        drive_eval(0, 0, 0, 0, od, os, lat, rdy, st, idl, to);
        compared++;
        if (to !== 1'b0 || od !== 16'sd32767 || os !== 1'b1) begin
            mismatched++;
            $display("FAIL sat_pos: data=%0d sat=%b want 32767 sat 1", od, os);
        end
        terms = '{-32768, -32768};
        drive_eval(0, 0, 0, 0, od, os, lat, rdy, st, idl, to);
        compared++;
        if (to !== 1'b0 || od !== -16'sd32768 || os !== 1'b1) begin
            mismatched++;
            $display("FAIL sat_neg: data=%0d sat=%b want -32768 sat 1", od, os);
        end
    endtask

    task automatic test_zero_len();
        logic signed [15:0] od; logic os; int lat, rdy; bit st, idl, to;
        terms = {};
        drive_eval(-128, 0, 0, 0, od, os, lat, rdy, st, idl, to);
        compared++;
        if (to !== 1'b0 || od !== -16'sd128 || os !== 1'b0) begin
            mismatched++;
            $display("FAIL zero_len: data=%0d sat=%b want -128 sat 0", od, os);
        end
        compared++;
        if (lat !== 2 || rdy !== 0) begin
            mismatched++;
            $display("FAIL zero_len_timing: lat=%0d ready_cycles=%0d want 2 and 0", lat, rdy);
        end
    endtask

    task automatic test_stall();
        logic signed [15:0] od; logic os; int lat, rdy; bit st, idl, to;
        longint res; bit sat;
        terms = '{1234, -77, 3000, 512};
        model(9, res, sat);
        drive_eval(9, 40, 5, 1, od, os, lat, rdy, st, idl, to);
        compared++;
        if (to !== 1'b0 || od !== 16'(res) || os !== sat) begin
            mismatched++;
            $display("FAIL stall_sum: data=%0d sat=%b want %0d sat %b", od, os, res, sat);
        end
        compared++;
        if (st !== 1'b1) begin
            mismatched++;
            $display("FAIL stall_stable: got %b want 1", st);
        end
        compared++;
        if (idl !== 1'b1) begin
            mismatched++;
            $display("FAIL stall_idle: got %b want 1", idl);
        end
    endtask

    task automatic test_reset_mid();
        logic signed [15:0] od; logic os; int lat, rdy; bit st, idl, to;
        cfg_len = 8'd4;
        bias = 8'sd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 16'sd10;
        @(posedge clk); #1;
        in_data = 16'sd20;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if ({out_valid, in_ready, busy, out_sat} !== 4'b0 || out_data !== 16'sd0) begin
            mismatched++;
            $display("FAIL reset_mid: ov=%b ir=%b busy=%b sat=%b data=%0d want all 0",
                     out_valid, in_ready, busy, out_sat, out_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        terms = '{7};
        drive_eval(1, 0, 0, 0, od, os, lat, rdy, st, idl, to);
        compared++;
        if (to !== 1'b0 || od !== 16'sd8 || os !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_recover: data=%0d sat=%b want 8 sat 0", od, os);
        end
    endtask

    task automatic test_random();
        logic signed [15:0] od; logic os; int lat, rdy; bit st, idl, to;
        longint res; bit sat;
        int n, b, mode;
        for (int it = 0; it < 20; it++) begin
            n = $urandom_range(255, 1);
            mode = $urandom_range(2);
            terms = {};
            for (int k = 0; k < n; k++) begin
                if (mode == 0) terms.push_back(int'($signed(16'($urandom))));
                else if (mode == 1) terms.push_back($urandom_range(32767, 20000));
                else terms.push_back(-int'($urandom_range(32768, 20000)));
            end
            b = int'($signed(8'($urandom)));
            model(b, res, sat);
            drive_eval(b, $urandom_range(50), $urandom_range(3), 1'b0,
                       od, os, lat, rdy, st, idl, to);
            compared++;
            if (to !== 1'b0 || od !== 16'(res) || os !== sat) begin
                mismatched++;
                $display("FAIL random[%0d]: len=%0d data=%0d sat=%b want %0d sat %b",
                         it, n, od, os, res, sat);
            end
            compared++;
            if (lat !== 2 || idl !== 1'b1) begin
                mismatched++;
                $display("FAIL random_timing[%0d]: lat=%0d idle=%b want 2 and 1", it, lat, idl);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_zero_len();
        test_stall();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
